// File: rtl/id_ex_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_skid_reg
// Purpose  : ID/EX pipeline register built as a two-entry skid buffer.
//            A main register drives the out_* fields. A skid register catches
//            one extra bundle so that in_ready can come straight from a flop.
//            A flush kills both entries and drops any push in the same cycle.
//            The data registers keep their contents on a flush. Only the
//            valid state is cleared.
//            out_ctrl is forced to zero while out_valid is low, so the execute
//            stage sees a NOP bubble.
// Ports    : clk, rst_n (async, active-low), flush
//            in_valid / in_ready   : decode-side handshake
//            in_imm, in_pc, in_rs1_data, in_rs2_data (32b), in_rd (5b),
//            in_ctrl (16b)         : decoded bundle
//            out_valid / out_ready : execute-side handshake
//            out_* fields          : mirror of the in_* fields
//            stall_cnt (32b)       : saturating stall counter. This port exists
//                                    only when IDEX_STALL_CNT_EN is defined.
// Config   : IDEX_STALL_CNT_EN -- adds the stall_cnt port and its counter.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_skid_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_ctrl,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_imm,
  output logic [31:0] out_pc,
  output logic [31:0] out_rs1_data,
  output logic [31:0] out_rs2_data,
  output logic [4:0]  out_rd,
  output logic [15:0] out_ctrl
`ifdef IDEX_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  // The bundle is packed as {imm, pc, rs1, rs2, rd, ctrl}.
  localparam int c_BUNDLE_W = 32 * 4 + 5 + 16;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic [c_BUNDLE_W-1:0]   r_main;
  logic [c_BUNDLE_W-1:0]   r_skid;

  logic [c_BUNDLE_W-1:0]   w_in_bundle;
  logic                    w_push;
  logic                    w_pop;
  state_t                  w_next_state;
  logic                    w_load_main_in;
  logic                    w_load_main_skid;
  logic                    w_load_skid;

  assign w_in_bundle = {in_imm, in_pc, in_rs1_data, in_rs2_data, in_rd, in_ctrl};
  assign w_push      = in_valid & r_in_ready;
  assign w_pop       = r_out_valid & out_ready;

  always_comb begin
    w_next_state     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      // The flush wins over every other event and leaves the data untouched.
      w_next_state = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_push) begin
            w_load_main_in = 1'b1;
            w_next_state   = S_ONE;
          end
        end
        S_ONE: begin
          if (w_push && !w_pop) begin
            w_load_skid  = 1'b1;
            w_next_state = S_TWO;
          end else if (w_push && w_pop) begin
            w_load_main_in = 1'b1;
          end else if (w_pop) begin
            w_next_state = S_EMPTY;
          end
        end
        S_TWO: begin
          // in_ready is low here, so no push can happen in this state.
          if (w_pop) begin
            w_load_main_skid = 1'b1;
            w_next_state     = S_ONE;
          end
        end
        default: w_next_state = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_main      <= '0;
      r_skid      <= '0;
    end else begin
      r_state     <= w_next_state;
      // The handshake outputs are registered copies of the next state.
      r_in_ready  <= (w_next_state != S_TWO);
      r_out_valid <= (w_next_state != S_EMPTY);
      if (w_load_main_in) begin
        r_main <= w_in_bundle;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_in_bundle;
      end
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_imm      = r_main[148:117];
  assign out_pc       = r_main[116:85];
  assign out_rs1_data = r_main[84:53];
  assign out_rs2_data = r_main[52:21];
  assign out_rd       = r_main[20:16];
  assign out_ctrl     = r_out_valid ? r_main[15:0] : 16'h0000;

`ifdef IDEX_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // The counter saturates. Only a reset clears it. A flush does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/id_ex_skid_reg.md
ID_EX_SKID_REG -- requirements
Module: id_ex_skid_reg

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port flush, input, 1 bit: synchronous pipeline kill from branch/jump resolution.
REQ-004 SHALL have port in_valid, input, 1 bit: the decode stage presents a valid bundle.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a bundle this cycle.
REQ-006 SHALL have ports in_imm, in_pc, in_rs1_data, in_rs2_data, input, 32 bits each: the decoded immediate, PC and register operands.
REQ-007 SHALL have ports in_rd, input, 5 bits; and in_ctrl, input, 16 bits: destination register and control bundle.
REQ-008 SHALL have port out_valid, output, 1 bit: the execute stage is presented with a valid bundle.
REQ-009 SHALL have port out_ready, input, 1 bit: the execute stage consumes the bundle.
REQ-010 SHALL have ports out_imm, out_pc, out_rs1_data, out_rs2_data (32 bits), out_rd (5 bits) and out_ctrl (16 bits), all outputs, mirroring the in_* fields.
REQ-011 SHALL have port stall_cnt, output, 32 bits, present only when IDEX_STALL_CNT_EN is defined.

Function
REQ-012 SHALL be built as a two-entry skid buffer: a main register driving out_*, plus one skid register.
REQ-013 SHALL use state EMPTY (no entry), ONE (main register valid) or TWO (main and skid valid).
REQ-014 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-015 SHALL drive in_ready from a register, high exactly when the state is not TWO.
REQ-016 SHALL drive out_valid high in states ONE and TWO.
REQ-017 SHALL make these transitions from EMPTY: on push, main <= in and go to ONE; otherwise stay in EMPTY.
REQ-018 SHALL make these transitions from ONE: push without pop -> skid <= in, go to TWO; push with pop -> main <= in, stay in ONE; pop without push -> EMPTY; neither -> hold.
REQ-019 SHALL make these transitions from TWO: pop -> main <= skid, go to ONE; no pop -> hold (push is impossible because in_ready = 0).
REQ-020 SHALL have a latency of 1 cycle from push to out_valid and sustain a throughput of 1 bundle per cycle when out_ready stays high.
REQ-021 SHALL give flush priority over every other event: the next state is EMPTY, both entries are discarded, and a same-cycle push is dropped.
REQ-022 SHALL leave data registers unchanged on flush; only the valid state changes.
REQ-023 SHALL force out_ctrl to 16'h0000 combinationally whenever out_valid = 0, so execute sees a NOP bubble; the other out_* fields hold their last values.
REQ-024 SHALL never reorder, duplicate or drop a bundle except on flush.

Reset
REQ-025 SHALL, while rst_n = 0, immediately force: state EMPTY, out_valid 0, in_ready 0, every data register 0 and stall_cnt 0.
REQ-026 SHALL raise in_ready on the first clk edge after rst_n deasserts.
REQ-027 SHALL abandon any in-flight bundle on a mid-operation reset, with no partial outputs.

Configuration
REQ-028 SHALL, with IDEX_STALL_CNT_EN defined, increment stall_cnt on every cycle where out_valid = 1 and out_ready = 0.
REQ-029 SHALL saturate stall_cnt at 32'hFFFFFFFF and clear it only on reset, not on flush.
REQ-030 SHALL, without IDEX_STALL_CNT_EN, have neither the stall_cnt port nor its counter logic; all other behaviour is identical.

Verification
REQ-031 SHALL cover streaming: push imm=32'h00000800, pc=32'h0000_0010 with out_ready held at 1 -> out_valid at the next edge with the same values, then one bundle out per cycle.
REQ-032 SHALL cover backpressure: out_ready=0, push A then B -> state TWO, in_ready=0, out shows A; set out_ready=1 -> A, then B on successive cycles, then EMPTY.
REQ-033 SHALL cover flush: state TWO, flush=1 together with in_valid=1 -> next cycle out_valid=0, out_ctrl=16'h0000, and the pushed bundle is never emitted.
REQ-034 SHALL cover reset: assert rst_n=0 mid-stream between clock edges -> out_valid=0 and out_imm=0 immediately; in_ready=1 one edge after release.
REQ-035 SHALL cover the counter with IDEX_STALL_CNT_EN defined: hold out_valid=1 and out_ready=0 for 5 cycles -> stall_cnt=5; preload the counter near saturation -> it holds at 32'hFFFFFFFF.
REQ-036 SHALL cover simultaneous push and pop in ONE: main is replaced by the new bundle, the state stays ONE, and the skid register is unused.
